// File: rtl/spwm_pkg.sv
// Shared definitions for the SPWM generator and the PWM measurer (medidor_pwm).
package spwm_pkg;

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    ALTO   = 2'd1,
    BAJO   = 2'd2
  } estado_t;

  localparam int ANCHO_CONTADOR      = 14;
  localparam int CONTADOR_PULSOS_PWM = 10000;
  localparam int MAX_PERIODO         = 16383;
  localparam int ANCHO_FILTRO        = 3;

endpackage

// File: rtl/detector_flancos.sv
// Input conditioning for medidor_pwm: 2-flop synchronizer, optional glitch
// filter (build with GLITCH_FILTER_EN), and rising/falling edge strobes.
import spwm_pkg::*;

module detector_flancos
`ifdef GLITCH_FILTER_EN
  #(parameter int Ancho_filtro = ANCHO_FILTRO)
`endif
  (
  input  logic clock,
  input  logic reset,
  input  logic rst_syn,
  input  logic pwm_in,
  output logic sube,
  output logic baja
);

  logic       sync_1;
  logic       sync_2;
  logic       muestra;
  logic       previo;
  logic [2:0] arranque;
  logic       listo;

  // Edges are held off until every stage holds a real pin sample, so a reset
  // while the pin is high does not look like a rising edge.
`ifdef GLITCH_FILTER_EN
  localparam logic [2:0] ARRANQUE = 3'd4;
`else
  localparam logic [2:0] ARRANQUE = 3'd3;
`endif

  assign listo = (arranque == ARRANQUE);

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else if (rst_syn) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= pwm_in;
      sync_2 <= sync_1;
    end
  end

  // Warm-up counter after any reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      arranque <= 3'd0;
    end else if (rst_syn) begin
      arranque <= 3'd0;
    end else if (!listo) begin
      arranque <= arranque + 3'd1;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int ANCHO_CF = $clog2(Ancho_filtro + 1);
  localparam logic [ANCHO_CF-1:0] LIM_CF = ANCHO_CF'(Ancho_filtro - 1);

  logic                filtrada;
  logic [ANCHO_CF-1:0] cnt_filtro;

  // Output follows the input only after Ancho_filtro consecutive differing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filtrada   <= 1'b0;
      cnt_filtro <= '0;
    end else if (rst_syn) begin
      filtrada   <= 1'b0;
      cnt_filtro <= '0;
    end else if (!listo) begin
      filtrada   <= sync_2;
      cnt_filtro <= '0;
    end else if (sync_2 != filtrada) begin
      if (cnt_filtro == LIM_CF) begin
        filtrada   <= sync_2;
        cnt_filtro <= '0;
      end else begin
        cnt_filtro <= cnt_filtro + 1'b1;
      end
    end else begin
      cnt_filtro <= '0;
    end
  end

  assign muestra = filtrada;
`else
  assign muestra = sync_2;
`endif

  // One-cycle-delayed copy for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      previo <= 1'b0;
    end else if (rst_syn) begin
      previo <= 1'b0;
    end else begin
      previo <= muestra;
    end
  end

  assign sube = listo &  muestra & ~previo;
  assign baja = listo & ~muestra &  previo;

endmodule

// File: rtl/medidor_pwm.sv
// PWM/SPWM measurer: reports high time and period of each complete period,
// in clocks, with a timeout for stuck-high / stuck-low inputs.
// Optional glitch filter on the input: define GLITCH_FILTER_EN.
//
// state  | meaning
// ESPERA | idle, waiting for a rising edge to start a period
// ALTO   | input high, counting high time and period
// BAJO   | input low, counting period; next rising edge closes it
import spwm_pkg::*;

module medidor_pwm #(
  parameter int Ancho_contador = ANCHO_CONTADOR,
  parameter int Max_periodo    = MAX_PERIODO
`ifdef GLITCH_FILTER_EN
  , parameter int Ancho_filtro = ANCHO_FILTRO
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rst_syn,
  input  logic                      e,
  input  logic                      pwm_in,
  output logic [Ancho_contador-1:0] ancho_pwm,
  output logic [Ancho_contador-1:0] periodo_pwm,
  output logic                      valido,
  output logic                      timeout
);

  localparam logic [Ancho_contador-1:0] MAXP = Ancho_contador'(Max_periodo);
  localparam logic [Ancho_contador-1:0] UNO  = Ancho_contador'(1);

  logic                      sube;
  logic                      baja;
  estado_t                   estado, estado_sig;
  logic [Ancho_contador-1:0] cnt_alto, cnt_alto_sig;
  logic [Ancho_contador-1:0] cnt_periodo, cnt_periodo_sig;
  logic [Ancho_contador-1:0] ancho_sig, periodo_sig;
  logic                      valido_sig, timeout_sig;
  logic [Ancho_contador-1:0] alto_inc, periodo_inc;

  detector_flancos
`ifdef GLITCH_FILTER_EN
    #(.Ancho_filtro(Ancho_filtro))
`endif
    u_detector (
    .clock   (clock),
    .reset   (reset),
    .rst_syn (rst_syn),
    .pwm_in  (pwm_in),
    .sube    (sube),
    .baja    (baja)
  );

  assign alto_inc    = (cnt_alto == MAXP)    ? MAXP : cnt_alto + 1'b1;
  assign periodo_inc = (cnt_periodo == MAXP) ? MAXP : cnt_periodo + 1'b1;

  // State, counters and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= ESPERA;
      cnt_alto    <= '0;
      cnt_periodo <= '0;
      ancho_pwm   <= '0;
      periodo_pwm <= '0;
      valido      <= 1'b0;
      timeout     <= 1'b0;
    end else if (rst_syn) begin
      estado      <= ESPERA;
      cnt_alto    <= '0;
      cnt_periodo <= '0;
      ancho_pwm   <= '0;
      periodo_pwm <= '0;
      valido      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      estado      <= estado_sig;
      cnt_alto    <= cnt_alto_sig;
      cnt_periodo <= cnt_periodo_sig;
      ancho_pwm   <= ancho_sig;
      periodo_pwm <= periodo_sig;
      valido      <= valido_sig;
      timeout     <= timeout_sig;
    end
  end

  // Next state, counter updates and result capture; an edge beats a timeout.
  always_comb begin
    estado_sig      = estado;
    cnt_alto_sig    = cnt_alto;
    cnt_periodo_sig = cnt_periodo;
    ancho_sig       = ancho_pwm;
    periodo_sig     = periodo_pwm;
    valido_sig      = 1'b0;
    timeout_sig     = 1'b0;
    if (!e) begin
      estado_sig      = ESPERA;
      cnt_alto_sig    = '0;
      cnt_periodo_sig = '0;
    end else begin
      case (estado)
        ESPERA: begin
          if (sube) begin
            cnt_alto_sig    = UNO;
            cnt_periodo_sig = UNO;
            estado_sig      = ALTO;
          end
        end
        ALTO: begin
          if (baja) begin
            cnt_periodo_sig = periodo_inc;
            estado_sig      = BAJO;
          end else if (cnt_periodo == MAXP) begin
            ancho_sig       = MAXP;
            periodo_sig     = MAXP;
            valido_sig      = 1'b1;
            timeout_sig     = 1'b1;
            cnt_alto_sig    = '0;
            cnt_periodo_sig = '0;
            estado_sig      = ESPERA;
          end else begin
            cnt_alto_sig    = alto_inc;
            cnt_periodo_sig = periodo_inc;
          end
        end
        BAJO: begin
          if (sube) begin
            ancho_sig       = cnt_alto;
            periodo_sig     = cnt_periodo;
            valido_sig      = 1'b1;
            cnt_alto_sig    = UNO;
            cnt_periodo_sig = UNO;
            estado_sig      = ALTO;
          end else if (cnt_periodo == MAXP) begin
            ancho_sig       = '0;
            periodo_sig     = MAXP;
            valido_sig      = 1'b1;
            timeout_sig     = 1'b1;
            cnt_alto_sig    = '0;
            cnt_periodo_sig = '0;
            estado_sig      = ESPERA;
          end else begin
            cnt_periodo_sig = periodo_inc;
          end
        end
        default: begin
          estado_sig      = ESPERA;
          cnt_alto_sig    = '0;
          cnt_periodo_sig = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_medidor_pwm.sv
// Scoreboard bench for medidor_pwm: directed pin waveforms push expected
// updates (values and arrival cycle); a monitor pops on every valido.
import spwm_pkg::*;

module tb_medidor_pwm;

`ifdef GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif
  localparam int W = ANCHO_CONTADOR;
  localparam int MAXP = MAX_PERIODO;
  localparam int PER = CONTADOR_PULSOS_PWM;

  logic         clock;
  logic         reset;
  logic         rst_syn;
  logic         e;
  logic         pwm_in;
  logic [W-1:0] ancho_pwm;
  logic [W-1:0] periodo_pwm;
  logic         valido;
  logic         timeout;

  typedef struct {
    int a;
    int p;
    int t;
    int c;
  } exp_t;

  exp_t sb[$];
  exp_t cab;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   r;

  medidor_pwm dut (
    .clock       (clock),
    .reset       (reset),
    .rst_syn     (rst_syn),
    .e           (e),
    .pwm_in      (pwm_in),
    .ancho_pwm   (ancho_pwm),
    .periodo_pwm (periodo_pwm),
    .valido      (valido),
    .timeout     (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", n, act, req, cyc);
    end
  endtask

  task automatic expect_upd(input int a, input int p, input int t, input int c);
    exp_t x;
    x.a = a;
    x.p = p;
    x.t = t;
    x.c = c;
    sb.push_back(x);
  endtask

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every valido must match the oldest expected update.
  always @(negedge clock) begin
    if (!reset) begin
      if (timeout && !valido) chk("timeout_sin_valido", 1, 0);
      if (valido) begin
        if (sb.size() == 0) begin
          chk("valido_inesperado", 1, 0);
        end else begin
          cab = sb.pop_front();
          chk("ancho_pwm", int'(ancho_pwm), cab.a);
          chk("periodo_pwm", int'(periodo_pwm), cab.p);
          chk("timeout", int'(timeout), cab.t);
          chk("ciclo_valido", cyc, cab.c);
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    rst_syn = 1'b0;
    e       = 1'b1;
    pwm_in  = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("reset_ancho", int'(ancho_pwm), 0);
    chk("reset_periodo", int'(periodo_pwm), 0);
    chk("reset_valido", int'(valido), 0);
    chk("reset_timeout", int'(timeout), 0);

    // 2500/7500: first period only starts the measurement
    drive(1'b1, PER / 4);
    drive(1'b0, PER - PER / 4);

    // second rising edge closes the first period; e dropped mid-low
    expect_upd(PER / 4, PER, 0, cyc + LAT);
    drive(1'b1, PER / 4);
    drive(1'b0, 3000);
    e = 1'b0;
    drive(1'b0, 250);
    chk("e_bajo_ancho", int'(ancho_pwm), PER / 4);
    chk("e_bajo_periodo", int'(periodo_pwm), PER);
    drive(1'b0, 250);
    e = 1'b1;
    drive(1'b0, 4000);

    // restart after e: no update here; rst_syn mid-high
    drive(1'b1, 1000);
    chk("antes_rst_ancho", int'(ancho_pwm), PER / 4);
    chk("antes_rst_periodo", int'(periodo_pwm), PER);
    rst_syn = 1'b1;
    @(negedge clock);
    rst_syn = 1'b0;
    chk("rst_syn_ancho", int'(ancho_pwm), 0);
    chk("rst_syn_periodo", int'(periodo_pwm), 0);
    chk("rst_syn_valido", int'(valido), 0);
    drive(1'b1, 1500);
    drive(1'b0, PER - PER / 4);

    // first rising edge after rst_syn only starts
    drive(1'b1, PER / 4);
    drive(1'b0, PER - PER / 4);

    // second edge closes 2500/10000, then stuck low -> timeout with 0%
    r = cyc;
    expect_upd(PER / 4, PER, 0, r + LAT);
    expect_upd(0, MAXP, 1, r + LAT + MAXP);
    drive(1'b1, PER / 4);
    drive(1'b0, MAXP + LAT + 10 - PER / 4);

    // stuck high -> timeout with 100%
    r = cyc;
    expect_upd(MAXP, MAXP, 1, r + LAT + MAXP);
    drive(1'b1, MAXP + LAT + 10);

    // 1000/1000 after timeout
    drive(1'b0, 1000);
    drive(1'b1, 1000);
    drive(1'b0, 1000);

    // 3000/7000 with a 1-clock glitch in the low phase
    expect_upd(1000, 2000, 0, cyc + LAT);
    drive(1'b1, 3000);
    drive(1'b0, 3000);
`ifndef GLITCH_FILTER_EN
    expect_upd(3000, 6000, 0, cyc + LAT);
`endif
    drive(1'b1, 1);
    drive(1'b0, 3999);
`ifdef GLITCH_FILTER_EN
    expect_upd(3000, PER, 0, cyc + LAT);
`else
    expect_upd(1, 4000, 0, cyc + LAT);
`endif
    drive(1'b1, 20);

    chk("actualizaciones_pendientes", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
